// File: rtl/direct_trans_req_arb_pkg.sv
// Shared constants and the round-robin search used by the direct-transfer
// request arbiter and its tag FIFO.
package direct_trans_arb_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_N_REQ  = 4;
  localparam int MAX_REQ        = 8;
  localparam int TAG_W          = $clog2(DEFAULT_N_REQ);

  // Result of one round-robin search: whether anyone won, and who.
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Tag width for a given requester count (never narrower than one bit).
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First asserted bit of valid, searching ptr, ptr+1, ... modulo n.
  // ptr is always below n, so a single subtraction folds the index back.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input logic [3:0]         n);
    rr_pick_t   res;
    logic [3:0] idx;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= n) idx = idx - n;
      if ((4'(k) < n) && !res.found && valid[idx[2:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/direct_trans_req_arb_if.sv
// Request/response stream bundle between the requesters, the arbiter and
// the direct transfer adaptor port.
// Handshake: a beat moves on a clock edge where TVALID and TREADY are both
// high; a source holds TVALID and TDATA until that edge, and TREADY may
// depend on TVALID but TVALID never waits on TREADY.
interface direct_trans_req_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64
);
  logic [N_REQ-1:0]        s_axis_req_TVALID;
  logic [N_REQ-1:0]        s_axis_req_TREADY;
  logic [N_REQ*DATA_W-1:0] s_axis_req_TDATA;
  logic                    m_axis_req_TVALID;
  logic                    m_axis_req_TREADY;
  logic [DATA_W-1:0]       m_axis_req_TDATA;
  logic                    s_axis_resp_TVALID;
  logic                    s_axis_resp_TREADY;
  logic [DATA_W-1:0]       s_axis_resp_TDATA;
  logic [N_REQ-1:0]        m_axis_resp_TVALID;
  logic [N_REQ-1:0]        m_axis_resp_TREADY;
  logic [DATA_W-1:0]       m_axis_resp_TDATA;

  // Arbiter view.
  modport slave (
    input  s_axis_req_TVALID, s_axis_req_TDATA, m_axis_req_TREADY,
    input  s_axis_resp_TVALID, s_axis_resp_TDATA, m_axis_resp_TREADY,
    output s_axis_req_TREADY, m_axis_req_TVALID, m_axis_req_TDATA,
    output s_axis_resp_TREADY, m_axis_resp_TVALID, m_axis_resp_TDATA
  );

  // Environment view (requesters plus adaptor port).
  modport master (
    output s_axis_req_TVALID, s_axis_req_TDATA, m_axis_req_TREADY,
    output s_axis_resp_TVALID, s_axis_resp_TDATA, m_axis_resp_TREADY,
    input  s_axis_req_TREADY, m_axis_req_TVALID, m_axis_req_TDATA,
    input  s_axis_resp_TREADY, m_axis_resp_TVALID, m_axis_resp_TDATA
  );
endinterface

// File: rtl/direct_trans_tag_fifo.sv
// In-order FIFO of requester tags, one entry per outstanding request.
// Pointers wrap in natural binary; the extra count bit separates full
// from empty.
module direct_trans_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; push and pop in one cycle cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/direct_trans_req_arb.sv
// Round-robin arbiter sharing one direct-transfer request/response channel
// pair between N_REQ requesters. Granted requester ids are queued in order
// so each response is routed back to whoever issued the matching request.
module direct_trans_req_arb
  import direct_trans_arb_pkg::*;
#(
  parameter int N_REQ      = DEFAULT_N_REQ,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int OUTS_DEPTH = 8
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  direct_trans_req_arb_if.slave         bus,
  output logic [$clog2(OUTS_DEPTH):0]   outstanding,
  output logic                          detect_fault
);
  localparam int TW    = tag_width(N_REQ);
  localparam int CNT_W = $clog2(OUTS_DEPTH) + 1;

  logic [TW-1:0]      rr_ptr;
  logic               req_valid_q;
  logic [DATA_W-1:0]  req_data_q;

  logic [MAX_REQ-1:0] valid_pad;
  rr_pick_t           pick;
  logic [TW-1:0]      winner;
  logic               slice_free;
  logic               can_grant;
  logic               accept;
  logic [N_REQ-1:0]   req_ready;

  logic               fifo_full;
  logic               fifo_empty;
  logic [TW-1:0]      head_tag;
  logic [CNT_W-1:0]   fifo_count;

  logic [N_REQ-1:0]   resp_valid;
  logic               resp_ready;
  logic               resp_pop;
  logic               resp_drop;

  // Round-robin search over the requesters that currently present a beat.
  always_comb begin
    valid_pad  = MAX_REQ'(bus.s_axis_req_TVALID);
    pick       = rr_pick(valid_pad, 3'(rr_ptr), 4'(N_REQ));
    winner     = TW'(pick.idx);
    slice_free = !req_valid_q || bus.m_axis_req_TREADY;
    // No same-cycle credit from a response pop: full is the current count.
    can_grant  = slice_free && !fifo_full;
    accept     = can_grant && pick.found;
  end

  // Only the winner sees ready, and only when the grant can be taken.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  // Registered request slice plus the round-robin pointer it advances.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      req_valid_q <= 1'b1;
      req_data_q  <= bus.s_axis_req_TDATA[winner*DATA_W +: DATA_W];
      rr_ptr      <= (winner == TW'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (bus.m_axis_req_TREADY) begin
      req_valid_q <= 1'b0;
    end
  end

  // Response routing by head tag; with nothing outstanding, beats are
  // swallowed so a stray response cannot stall the datapath.
  always_comb begin
    resp_valid = '0;
    resp_ready = 1'b1;
    resp_pop   = 1'b0;
    resp_drop  = 1'b0;
    if (!fifo_empty) begin
      resp_valid[head_tag] = bus.s_axis_resp_TVALID;
      resp_ready           = bus.m_axis_resp_TREADY[head_tag];
      resp_pop             = bus.s_axis_resp_TVALID && bus.m_axis_resp_TREADY[head_tag];
    end else begin
      resp_drop            = bus.s_axis_resp_TVALID;
    end
  end

  // Sticky record of any response that arrived with no request pending.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)      detect_fault <= 1'b0;
    else if (resp_drop) detect_fault <= 1'b1;
  end

  direct_trans_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (OUTS_DEPTH)
  ) u_tag_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (accept),
    .pop   (resp_pop),
    .din   (winner),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.s_axis_req_TREADY  = req_ready;
  assign bus.m_axis_req_TVALID  = req_valid_q;
  assign bus.m_axis_req_TDATA   = req_data_q;
  assign bus.s_axis_resp_TREADY = resp_ready;
  assign bus.m_axis_resp_TVALID = resp_valid;
  assign bus.m_axis_resp_TDATA  = bus.s_axis_resp_TDATA;
  assign outstanding            = fifo_count;
endmodule

// File: tb/tb_direct_trans_req_arb.sv
// Bench for direct_trans_req_arb: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_direct_trans_req_arb;
  localparam int N = 4;
  localparam int W = 64;
  localparam int D = 8;

  // ---------------- clock / reset ----------------
  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b1;
  always #5 ap_clk = ~ap_clk;

  direct_trans_req_arb_if #(.N_REQ(N), .DATA_W(W)) bus ();
  logic [3:0] outstanding;
  logic       detect_fault;

  direct_trans_req_arb #(.N_REQ(N), .DATA_W(W), .OUTS_DEPTH(D)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .bus          (bus),
    .outstanding  (outstanding),
    .detect_fault (detect_fault)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];   // requests forwarded but not yet taken downstream
  int           tag_q[$];   // requester ids awaiting their response
  logic         mdl_valid;
  int           mdl_rr;
  logic         mdl_fault;
  int           exp_win;
  logic [N-1:0] exp_req_ready;
  logic [N-1:0] exp_resp_valid;
  logic         exp_resp_ready;

  task automatic model_reset();
    exp_q.delete();
    tag_q.delete();
    mdl_valid = 1'b0;
    mdl_rr    = 0;
    mdl_fault = 1'b0;
  endtask

  // Expected combinational outputs for the inputs currently driven.
  task automatic model_eval();
    bit free;
    free    = !mdl_valid || bus.m_axis_req_TREADY;
    exp_win = -1;
    if (free && tag_q.size() < D)
      for (int k = 0; k < N; k++)
        if (exp_win < 0 && bus.s_axis_req_TVALID[(mdl_rr + k) % N]) exp_win = (mdl_rr + k) % N;
    exp_req_ready = '0;
    if (exp_win >= 0) exp_req_ready[exp_win] = 1'b1;
    exp_resp_valid = '0;
    exp_resp_ready = 1'b1;
    if (tag_q.size() > 0) begin
      exp_resp_valid[tag_q[0]] = bus.s_axis_resp_TVALID;
      exp_resp_ready           = bus.m_axis_resp_TREADY[tag_q[0]];
    end
  endtask

  // Advance the model across one clock edge.
  task automatic model_commit();
    if (mdl_valid && bus.m_axis_req_TREADY) begin
      void'(exp_q.pop_front());
      mdl_valid = 1'b0;
    end
    if (tag_q.size() > 0) begin
      if (bus.s_axis_resp_TVALID && bus.m_axis_resp_TREADY[tag_q[0]]) void'(tag_q.pop_front());
    end else if (bus.s_axis_resp_TVALID) begin
      mdl_fault = 1'b1;
    end
    if (exp_win >= 0) begin
      exp_q.push_back(bus.s_axis_req_TDATA[exp_win*W +: W]);
      tag_q.push_back(exp_win);
      mdl_valid = 1'b1;
      mdl_rr    = (exp_win + 1) % N;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_eval();
    model_commit();
    @(posedge ap_clk);
  endtask

  task automatic drive_idle();
    bus.s_axis_req_TVALID  = '0;
    bus.s_axis_req_TDATA   = '0;
    bus.m_axis_req_TREADY  = 1'b0;
    bus.s_axis_resp_TVALID = 1'b0;
    bus.s_axis_resp_TDATA  = '0;
    bus.m_axis_resp_TREADY = '0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d);
    bus.s_axis_req_TVALID[i]      = 1'b1;
    bus.s_axis_req_TDATA[i*W +: W] = d;
  endtask

  task automatic apply_reset();
    @(negedge ap_clk);
    drive_idle();
    ap_rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  // Answer every outstanding request with consumers always ready.
  task automatic drain();
    for (int c = 0; c < 3 * D; c++) begin
      @(negedge ap_clk);
      drive_idle();
      bus.m_axis_req_TREADY  = 1'b1;
      bus.m_axis_resp_TREADY = '1;
      bus.s_axis_resp_TVALID = (tag_q.size() > 0);
      bus.s_axis_resp_TDATA  = {$urandom, $urandom};
      #1;
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    ap_rst_n = 1'b1;
    #1 ap_rst_n = 1'b0;
    model_reset();
    @(negedge ap_clk);
    #1;
    checks++; if (bus.m_axis_req_TVALID !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %b expected 0", bus.m_axis_req_TVALID); end
    checks++; if (bus.m_axis_req_TDATA !== '0) begin errors++; $display("FAIL reset_mdata: got %h expected 0", bus.m_axis_req_TDATA); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    checks++; if (detect_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", detect_fault); end
    checks++; if (bus.s_axis_resp_TREADY !== 1'b1) begin errors++; $display("FAIL reset_resp_ready: got %b expected 1", bus.s_axis_resp_TREADY); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge ap_clk);
    drive_idle();
    bus.m_axis_req_TREADY  = 1'b1;
    bus.m_axis_resp_TREADY = '1;
    set_req(2, 64'hA5A5);
    #1;
    checks++; if (bus.s_axis_req_TREADY !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", bus.s_axis_req_TREADY); end
    tick();
    @(negedge ap_clk);
    bus.s_axis_req_TVALID = '0;
    #1;
    checks++; if (bus.m_axis_req_TVALID !== 1'b1 || bus.m_axis_req_TDATA !== 64'hA5A5) begin errors++; $display("FAIL single_fwd: got v=%b d=%h expected v=1 d=a5a5", bus.m_axis_req_TVALID, bus.m_axis_req_TDATA); end
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL single_outs1: got %0d expected 1", outstanding); end
    tick();
    @(negedge ap_clk);
    bus.s_axis_resp_TVALID = 1'b1;
    bus.s_axis_resp_TDATA  = 64'h1;
    #1;
    checks++; if (bus.m_axis_resp_TVALID !== 4'b0100 || bus.m_axis_resp_TDATA !== 64'h1) begin errors++; $display("FAIL single_route: got v=%b d=%h expected v=0100 d=1", bus.m_axis_resp_TVALID, bus.m_axis_resp_TDATA); end
    checks++; if (bus.s_axis_resp_TREADY !== 1'b1) begin errors++; $display("FAIL single_resp_ready: got %b expected 1", bus.s_axis_resp_TREADY); end
    tick();
    @(negedge ap_clk);
    bus.s_axis_resp_TVALID = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL single_outs0: got %0d expected 0", outstanding); end
    tick();
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int k = 0; k < D; k++) begin
      @(negedge ap_clk);
      drive_idle();
      bus.m_axis_req_TREADY = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 64'(k * 256 + i));
      #1;
      checks++; if (bus.s_axis_req_TREADY !== 4'(1 << (k % N))) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, bus.s_axis_req_TREADY, 4'(1 << (k % N))); end
      if (k > 0) begin
        checks++; if (bus.m_axis_req_TDATA !== 64'((k - 1) * 256 + (k - 1) % N)) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", k, bus.m_axis_req_TDATA, 64'((k - 1) * 256 + (k - 1) % N)); end
      end
      tick();
    end
    for (int k = 0; k < D; k++) begin
      @(negedge ap_clk);
      drive_idle();
      bus.m_axis_req_TREADY  = 1'b1;
      bus.m_axis_resp_TREADY = '1;
      bus.s_axis_resp_TVALID = 1'b1;
      #1;
      checks++; if (bus.m_axis_resp_TVALID !== 4'(1 << (k % N))) begin errors++; $display("FAIL rr_resp%0d: got %b expected %b", k, bus.m_axis_resp_TVALID, 4'(1 << (k % N))); end
      tick();
    end
    @(negedge ap_clk);
    drive_idle();
    #1;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rr_outs: got %0d expected 0", outstanding); end
    tick();
  endtask

  task automatic test_backpressure();
    @(negedge ap_clk);
    drive_idle();
    bus.m_axis_req_TREADY = 1'b1;
    set_req(1, 64'hB0B0_0001);
    #1;
    checks++; if (bus.s_axis_req_TREADY !== 4'b0010) begin errors++; $display("FAIL bp_first: got %b expected 0010", bus.s_axis_req_TREADY); end
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      drive_idle();
      for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom});
      #1;
      checks++; if (bus.s_axis_req_TREADY !== 4'b0000) begin errors++; $display("FAIL bp_stall%0d: got %b expected 0000", c, bus.s_axis_req_TREADY); end
      checks++; if (bus.m_axis_req_TVALID !== 1'b1 || bus.m_axis_req_TDATA !== 64'hB0B0_0001) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=b0b00001", c, bus.m_axis_req_TVALID, bus.m_axis_req_TDATA); end
      tick();
    end
    @(negedge ap_clk);
    bus.m_axis_req_TREADY = 1'b1;
    #1;
    checks++; if (bus.s_axis_req_TREADY !== 4'b0100) begin errors++; $display("FAIL bp_next: got %b expected 0100", bus.s_axis_req_TREADY); end
    tick();
    drain();
  endtask

  task automatic test_full();
    for (int k = 0; k < D; k++) begin
      @(negedge ap_clk);
      drive_idle();
      bus.m_axis_req_TREADY = 1'b1;
      set_req(0, {$urandom, $urandom});
      #1;
      checks++; if (bus.s_axis_req_TREADY !== 4'b0001) begin errors++; $display("FAIL full_fill%0d: got %b expected 0001", k, bus.s_axis_req_TREADY); end
      tick();
    end
    @(negedge ap_clk);
    set_req(0, 64'hF00D);
    #1;
    checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", outstanding); end
    checks++; if (bus.s_axis_req_TREADY !== 4'b0000) begin errors++; $display("FAIL full_stall: got %b expected 0000", bus.s_axis_req_TREADY); end
    checks++; if (bus.m_axis_req_TDATA !== exp_q[0]) begin errors++; $display("FAIL full_data: got %h expected %h", bus.m_axis_req_TDATA, exp_q[0]); end
    tick();
    @(negedge ap_clk);
    bus.s_axis_resp_TVALID = 1'b1;
    bus.m_axis_resp_TREADY = '1;
    #1;
    checks++; if (bus.s_axis_resp_TREADY !== 1'b1 || bus.m_axis_resp_TVALID !== 4'b0001) begin errors++; $display("FAIL full_resp: got r=%b v=%b expected r=1 v=0001", bus.s_axis_resp_TREADY, bus.m_axis_resp_TVALID); end
    checks++; if (bus.s_axis_req_TREADY !== 4'b0000) begin errors++; $display("FAIL full_no_credit: got %b expected 0000", bus.s_axis_req_TREADY); end
    tick();
    @(negedge ap_clk);
    bus.s_axis_resp_TVALID = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd7 || bus.s_axis_req_TREADY !== 4'b0001) begin errors++; $display("FAIL full_regrant: got outs=%0d rdy=%b expected outs=7 rdy=0001", outstanding, bus.s_axis_req_TREADY); end
    tick();
    @(negedge ap_clk);
    bus.s_axis_req_TVALID = '0;
    #1;
    checks++; if (outstanding !== 4'd8 || bus.m_axis_req_TDATA !== 64'hF00D) begin errors++; $display("FAIL full_refill: got outs=%0d d=%h expected outs=8 d=f00d", outstanding, bus.m_axis_req_TDATA); end
    tick();
    drain();
  endtask

  task automatic test_unexpected_resp();
    @(negedge ap_clk);
    drive_idle();
    bus.s_axis_resp_TVALID = 1'b1;
    bus.s_axis_resp_TDATA  = 64'hDEAD;
    #1;
    checks++; if (bus.s_axis_resp_TREADY !== 1'b1 || bus.m_axis_resp_TVALID !== 4'b0000) begin errors++; $display("FAIL stray_route: got r=%b v=%b expected r=1 v=0000", bus.s_axis_resp_TREADY, bus.m_axis_resp_TVALID); end
    checks++; if (detect_fault !== 1'b0) begin errors++; $display("FAIL stray_pre: got %b expected 0", detect_fault); end
    tick();
    @(negedge ap_clk);
    drive_idle();
    #1;
    checks++; if (detect_fault !== 1'b1 || outstanding !== 4'd0) begin errors++; $display("FAIL stray_fault: got f=%b outs=%0d expected f=1 outs=0", detect_fault, outstanding); end
    tick();
    @(negedge ap_clk);
    bus.m_axis_req_TREADY = 1'b1;
    set_req(3, 64'h3333);
    #1;
    tick();
    drain();
    @(negedge ap_clk);
    drive_idle();
    #1;
    checks++; if (detect_fault !== 1'b1 || outstanding !== 4'd0) begin errors++; $display("FAIL stray_sticky: got f=%b outs=%0d expected f=1 outs=0", detect_fault, outstanding); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      drive_idle();
      bus.m_axis_req_TREADY = 1'b1;
      set_req(k, 64'(16'hC000 + k));
      #1;
      tick();
    end
    @(negedge ap_clk);
    drive_idle();
    for (int i = 0; i < N; i++) set_req(i, 64'h77);
    #1;
    checks++; if (outstanding !== 4'd3 || bus.m_axis_req_TDATA !== 64'hC002) begin errors++; $display("FAIL mid_before: got outs=%0d d=%h expected outs=3 d=c002", outstanding, bus.m_axis_req_TDATA); end
    ap_rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.m_axis_req_TVALID !== 1'b0 || bus.m_axis_req_TDATA !== '0) begin errors++; $display("FAIL mid_slice: got v=%b d=%h expected v=0 d=0", bus.m_axis_req_TVALID, bus.m_axis_req_TDATA); end
    checks++; if (outstanding !== 4'd0 || detect_fault !== 1'b0) begin errors++; $display("FAIL mid_state: got outs=%0d f=%b expected outs=0 f=0", outstanding, detect_fault); end
    drive_idle();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    bus.s_axis_resp_TVALID = 1'b1;
    bus.m_axis_resp_TREADY = '1;
    #1;
    checks++; if (bus.m_axis_resp_TVALID !== 4'b0000) begin errors++; $display("FAIL mid_no_route: got %b expected 0000", bus.m_axis_resp_TVALID); end
    tick();
    @(negedge ap_clk);
    drive_idle();
    #1;
    checks++; if (detect_fault !== 1'b1) begin errors++; $display("FAIL mid_fault: got %b expected 1", detect_fault); end
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge ap_clk);
      bus.s_axis_req_TVALID = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) bus.s_axis_req_TDATA[i*W +: W] = {$urandom, $urandom};
      bus.m_axis_req_TREADY  = ($urandom_range(0, 3) != 0);
      bus.m_axis_resp_TREADY = 4'($urandom_range(0, 15));
      bus.s_axis_resp_TVALID = (tag_q.size() > 0) && ($urandom_range(0, 2) != 0);
      bus.s_axis_resp_TDATA  = {$urandom, $urandom};
      #1;
      model_eval();
      checks++; if (bus.s_axis_req_TREADY !== exp_req_ready) begin errors++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, bus.s_axis_req_TREADY, exp_req_ready); end
      checks++; if (bus.m_axis_req_TVALID !== mdl_valid) begin errors++; $display("FAIL rnd_mvalid c%0d: got %b expected %b", c, bus.m_axis_req_TVALID, mdl_valid); end
      if (mdl_valid) begin
        checks++; if (bus.m_axis_req_TDATA !== exp_q[0]) begin errors++; $display("FAIL rnd_mdata c%0d: got %h expected %h", c, bus.m_axis_req_TDATA, exp_q[0]); end
      end
      checks++; if (bus.m_axis_resp_TVALID !== exp_resp_valid || bus.s_axis_resp_TREADY !== exp_resp_ready) begin errors++; $display("FAIL rnd_resp c%0d: got v=%b r=%b expected v=%b r=%b", c, bus.m_axis_resp_TVALID, bus.s_axis_resp_TREADY, exp_resp_valid, exp_resp_ready); end
      checks++; if (bus.m_axis_resp_TDATA !== bus.s_axis_resp_TDATA) begin errors++; $display("FAIL rnd_rdata c%0d: got %h expected %h", c, bus.m_axis_resp_TDATA, bus.s_axis_resp_TDATA); end
      checks++; if (outstanding !== 4'(tag_q.size()) || detect_fault !== mdl_fault) begin errors++; $display("FAIL rnd_state c%0d: got outs=%0d f=%b expected outs=%0d f=%b", c, outstanding, detect_fault, tag_q.size(), mdl_fault); end
      tick();
    end
    drain();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full();
    test_unexpected_resp();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/direct_trans_req_arb.md
Name: direct_trans_req_arb

Overview:
- Round-robin arbiter that shares one direct-transfer request/response channel pair (64-bit req out, 64-bit resp in) between N_REQ requesters.
- Sits between the chain-control requesters and a single tx_req/tx_resp port of the direct transfer adaptor.
- Records the granted requester of every forwarded request in an in-order tag FIFO and routes each response back to that requester.
- Flags a sticky fault when a response arrives with no request outstanding.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 64, request/response TDATA width.
- OUTS_DEPTH, 8, max outstanding requests; power of 2, ≥2.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- s_axis_req_TVALID  in  N_REQ  per-requester request valid
- s_axis_req_TREADY  out  N_REQ  per-requester request ready
- s_axis_req_TDATA  in  N_REQ*DATA_W  requester i at bits [i*DATA_W +: DATA_W]
- m_axis_req_TVALID  out  1  arbitrated request valid
- m_axis_req_TREADY  in  1  downstream ready
- m_axis_req_TDATA  out  DATA_W  arbitrated request
- s_axis_resp_TVALID  in  1  response valid from datapath
- s_axis_resp_TREADY  out  1  response ready
- s_axis_resp_TDATA  in  DATA_W  response
- m_axis_resp_TVALID  out  N_REQ  routed response valid
- m_axis_resp_TREADY  in  N_REQ  per-requester response ready
- m_axis_resp_TDATA  out  DATA_W  response data, broadcast to all requesters
- outstanding  out  clog2(OUTS_DEPTH)+1  current tag FIFO occupancy
- detect_fault  out  1  sticky: unexpected response seen

Behaviour:
- Reset (async assert, sync release): m_axis_req_TVALID=0, TDATA=0, rr_ptr=0, FIFO empty, outstanding=0, detect_fault=0. Reset mid-operation discards the held request and all tags.
- Request output is a registered slice. The slice is "free" when !m_axis_req_TVALID || m_axis_req_TREADY.
- can_grant = free && !fifo_full. fifo_full is judged on the current count only: there is no same-cycle pop credit.
- Arbitration: when can_grant, pick the first asserted TVALID searching rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Only the winner sees s_axis_req_TREADY=1; all others see 0.
  - When can_grant=0, all TREADY are 0.
  - s_axis_req_TREADY does not depend on s_axis_req_TVALID of other requesters beyond the arbitration search.
- On an accepted request (winner w):
  - load TDATA[w] into the slice and set m_axis_req_TVALID=1 next cycle;
  - push tag w;
  - rr_ptr <= (w+1) mod N_REQ.
- With no acceptance, rr_ptr holds. Latency is 1 cycle, input handshake to m_axis_req_TVALID.
- While TVALID && !TREADY, m_axis_req_TDATA is held stable. Full throughput is 1 request per cycle.
- Response path is combinational, with head tag h:
  - FIFO non-empty: m_axis_resp_TVALID[h]=s_axis_resp_TVALID, all other bits 0; s_axis_resp_TREADY=m_axis_resp_TREADY[h]; pop on the s_axis_resp handshake.
  - FIFO empty: all m_axis_resp_TVALID=0 and s_axis_resp_TREADY=1. Any response beat is dropped and detect_fault<=1. detect_fault clears only on reset.
- Simultaneous push and pop: occupancy is unchanged, both operations take effect, and the head advances correctly. A tag pushed this cycle is not visible as head until the next cycle.
- outstanding = FIFO count, which increments on accept and decrements on response handshake.
- Pointer wrap-around at OUTS_DEPTH is natural binary. The count uses the extra bit to tell full from empty.

Decomposition:
- Package direct_trans_arb_pkg holds TAG_W = clog2(N_REQ), the DATA_W default and a helper function for the round-robin search.
- One sub-module: direct_trans_tag_fifo.
  - Synchronous FIFO, width TAG_W, depth OUTS_DEPTH.
  - Ports: push, pop, din, dout (head), full, empty, count.
  - Same clock and reset as the parent.

Test Plan:
- Single requester 2 sends 0xA5A5 with m_axis_req_TREADY=1 → m_axis_req_TDATA=0xA5A5 one cycle later; response 0x1 appears only on m_axis_resp_TVALID[2]; outstanding goes 0→1→0.
- All 4 requesters valid continuously, downstream always ready → grant order 0,1,2,3,0,1,… with one grant per cycle. Responses return to 0,1,2,3 in order.
- m_axis_req_TREADY=0 for 5 cycles with a request held → TDATA stable and no s_axis_req_TREADY asserted. When ready rises, the next grant follows the rr_ptr order.
- Issue 8 requests with no responses → outstanding=8 and the 9th is stalled (TREADY=0). One response is accepted → the 9th is granted the next cycle, with outstanding back at 8.
- Response with the FIFO empty → s_axis_resp_TREADY=1, beat dropped, no m_axis_resp_TVALID, detect_fault=1 and it stays 1 after further normal traffic.
- ap_rst_n pulsed low with 3 outstanding and a held request → all outputs return to reset values immediately; a subsequent response sets detect_fault.
